// File: rtl/sdx_sched_pkg.sv
// Shared types and default constants for the chunk scheduler.
package sdx_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

    localparam int unsigned SCHED_CHUNK_BYTES    = 4096;
    localparam int unsigned SCHED_BEAT_BYTES     = 64;
    localparam int unsigned SCHED_TIMEOUT_CYCLES = 65536;

    // Ceiling log2, used to find the beat-alignment shift.
    function automatic int unsigned sched_log2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sdx_sched_watchdog.sv
// WAIT-state watchdog: counts enabled cycles, flags expiry on the C_LIMIT-th one.
module sdx_sched_watchdog #(
    parameter int unsigned C_LIMIT = 65536
) (
    input  logic ap_clk,
    input  logic areset,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(C_LIMIT + 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge ap_clk) begin
        if (areset || clear) begin
            count <= '0;
        end else if (enable && !expired_c) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = enable && (count == CNT_W'(C_LIMIT - 1));

endmodule

// File: rtl/sdx_kernel_chunk_scheduler.sv
// Splits a host job into engine-sized chunks and sequences the engine handshake.
// Optional WAIT watchdog enabled by defining SDX_SCHED_TIMEOUT_EN.
module sdx_kernel_chunk_scheduler
    import sdx_sched_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH      = 64,
    parameter int unsigned C_XFER_SIZE_WIDTH = 32,
    parameter int unsigned C_CHUNK_BYTES     = SCHED_CHUNK_BYTES,
    parameter int unsigned C_BEAT_BYTES      = SCHED_BEAT_BYTES,
    parameter int unsigned C_TIMEOUT_CYCLES  = SCHED_TIMEOUT_CYCLES
) (
    input  logic                         ap_clk,
    input  logic                         areset,
    input  logic                         ap_start,
    output logic                         ap_idle,
    output logic                         ap_done,
    input  logic [C_ADDR_WIDTH-1:0]      ctrl_base_addr,
    input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_total_bytes,
    output logic                         eng_start,
    output logic [C_ADDR_WIDTH-1:0]      eng_addr_offset,
    output logic [C_XFER_SIZE_WIDTH-1:0] eng_xfer_size,
    input  logic                         eng_done,
    output logic [C_XFER_SIZE_WIDTH-1:0] chunk_idx,
    output logic                         sched_timeout
);

    localparam int unsigned BEAT_LOG2 = sched_log2(C_BEAT_BYTES);
    localparam logic [C_XFER_SIZE_WIDTH-1:0] CHUNK_SIZE = C_XFER_SIZE_WIDTH'(C_CHUNK_BYTES);

    // Elaboration-time sanity check of the geometry parameters.
    if (((C_CHUNK_BYTES & (C_CHUNK_BYTES - 1)) != 0) ||
        ((C_CHUNK_BYTES % C_BEAT_BYTES) != 0) || (C_TIMEOUT_CYCLES == 0)) begin : g_bad_params
        $error("sdx_kernel_chunk_scheduler: invalid chunk/beat/timeout parameters");
    end

    sched_state_t                 state, state_n;
    logic                         ap_start_r;
    logic                         start_pulse_c;
    logic [C_ADDR_WIDTH-1:0]      cursor, cursor_n;
    logic [C_XFER_SIZE_WIDTH-1:0] remaining, remaining_n;
    logic [C_XFER_SIZE_WIDTH-1:0] chunk_idx_n;
    logic [C_XFER_SIZE_WIDTH-1:0] chunk_size_c;
    logic                         wd_expired_c;

    assign start_pulse_c = ap_start & ~ap_start_r;
    assign chunk_size_c  = (remaining_n < CHUNK_SIZE) ? remaining_n : CHUNK_SIZE;

    // Next-state and chunk bookkeeping.
    always_comb begin
        state_n     = state;
        cursor_n    = cursor;
        remaining_n = remaining;
        chunk_idx_n = chunk_idx;
        case (state)
            IDLE: begin
                if (start_pulse_c) begin
                    cursor_n    = ctrl_base_addr;
                    remaining_n = (ctrl_total_bytes >> BEAT_LOG2) << BEAT_LOG2;
                    state_n     = (remaining_n == '0) ? DONE : ISSUE;
                end
            end
            ISSUE: begin
                state_n = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    cursor_n    = cursor + C_ADDR_WIDTH'(eng_xfer_size);
                    remaining_n = remaining - eng_xfer_size;
                    if (remaining_n == '0) begin
                        state_n = DONE;
                    end else begin
                        chunk_idx_n = chunk_idx + C_XFER_SIZE_WIDTH'(1);
                        state_n     = ISSUE;
                    end
                end else if (wd_expired_c) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                chunk_idx_n = '0;
                state_n     = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, bookkeeping and registered outputs, all decoded from the next state.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state           <= IDLE;
            ap_start_r      <= 1'b0;
            cursor          <= '0;
            remaining       <= '0;
            chunk_idx       <= '0;
            ap_idle         <= 1'b1;
            ap_done         <= 1'b0;
            eng_start       <= 1'b0;
            eng_addr_offset <= '0;
            eng_xfer_size   <= '0;
        end else begin
            state      <= state_n;
            ap_start_r <= ap_start;
            cursor     <= cursor_n;
            remaining  <= remaining_n;
            chunk_idx  <= chunk_idx_n;
            ap_idle    <= (state_n == IDLE) || (state_n == DONE);
            ap_done    <= (state_n == DONE);
            eng_start  <= (state_n == ISSUE);
            if (state_n == ISSUE) begin
                eng_addr_offset <= cursor_n;
                eng_xfer_size   <= chunk_size_c;
            end
        end
    end

`ifdef SDX_SCHED_TIMEOUT_EN
    logic wd_clear_c;
    logic wd_enable_c;

    assign wd_clear_c  = (state != WAIT);
    assign wd_enable_c = (state == WAIT);

    sdx_sched_watchdog #(
        .C_LIMIT (C_TIMEOUT_CYCLES)
    ) u_watchdog (
        .ap_clk    (ap_clk),
        .areset    (areset),
        .clear     (wd_clear_c),
        .enable    (wd_enable_c),
        .expired_c (wd_expired_c)
    );

    // Sticky until reset or the next accepted job.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            sched_timeout <= 1'b0;
        end else if ((state == WAIT) && !eng_done && wd_expired_c) begin
            sched_timeout <= 1'b1;
        end else if ((state == IDLE) && start_pulse_c) begin
            sched_timeout <= 1'b0;
        end
    end
`else
    assign wd_expired_c  = 1'b0;
    assign sched_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sdx_kernel_chunk_scheduler.sv
// Self-checking bench for sdx_kernel_chunk_scheduler: directed table, corner sequences, random jobs.
module tb_sdx_kernel_chunk_scheduler;

    localparam int unsigned CHUNK = 4096;
    localparam int unsigned BEAT  = 64;
    localparam int unsigned TMO   = 100;

    logic        ap_clk = 1'b0;
    logic        areset;
    logic        ap_start;
    logic        ap_idle;
    logic        ap_done;
    logic [63:0] ctrl_base_addr;
    logic [31:0] ctrl_total_bytes;
    logic        eng_start;
    logic [63:0] eng_addr_offset;
    logic [31:0] eng_xfer_size;
    logic        eng_done;
    logic [31:0] chunk_idx;
    logic        sched_timeout;

    always #5 ap_clk = ~ap_clk;

    sdx_kernel_chunk_scheduler #(
        .C_ADDR_WIDTH      (64),
        .C_XFER_SIZE_WIDTH (32),
        .C_CHUNK_BYTES     (CHUNK),
        .C_BEAT_BYTES      (BEAT),
        .C_TIMEOUT_CYCLES  (TMO)
    ) dut (
        .ap_clk           (ap_clk),
        .areset           (areset),
        .ap_start         (ap_start),
        .ap_idle          (ap_idle),
        .ap_done          (ap_done),
        .ctrl_base_addr   (ctrl_base_addr),
        .ctrl_total_bytes (ctrl_total_bytes),
        .eng_start        (eng_start),
        .eng_addr_offset  (eng_addr_offset),
        .eng_xfer_size    (eng_xfer_size),
        .eng_done         (eng_done),
        .chunk_idx        (chunk_idx),
        .sched_timeout    (sched_timeout)
    );

    typedef struct {
        logic [63:0] base;
        logic [31:0] total;
        bit          disturb;
        int          exp_chunks;
        logic [63:0] exp_last_addr;
        logic [31:0] exp_last_size;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] exp_addr_q[$];
    logic [31:0] exp_size_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    // Reference: the list of (address, size) chunks the job should produce.
    task automatic model_job(input logic [63:0] base, input logic [31:0] total);
        logic [63:0] rem;
        logic [63:0] addr;
        logic [63:0] sz;
        exp_addr_q.delete();
        exp_size_q.delete();
        rem  = (64'(total) / BEAT) * BEAT;
        addr = base;
        while (rem != 0) begin
            sz = (rem > CHUNK) ? 64'(CHUNK) : rem;
            exp_addr_q.push_back(addr);
            exp_size_q.push_back(32'(sz));
            addr = addr + sz;
            rem  = rem - sz;
        end
    endtask

    // Runs one job from an idle DUT, acting as the engine, checking every chunk.
    task automatic run_job(input logic [63:0] base, input logic [31:0] total, input bit disturb,
                           output int n_starts, output logic [63:0] last_addr,
                           output logic [31:0] last_size);
        int   exp_n, cycles, done_delay, idle_bad, n_done;
        bit   finished, done_driven;
        logic eng_done_nx;
        logic [63:0] ea;
        logic [31:0] es;
        model_job(base, total);
        exp_n      = exp_addr_q.size();
        n_starts   = 0;
        n_done     = 0;
        last_addr  = '0;
        last_size  = '0;
        idle_bad   = 0;
        done_delay = -1;
        finished   = 0;
        done_driven = 0;
        cycles     = 1;

        ctrl_base_addr   = base;
        ctrl_total_bytes = total;
        ap_start = 1'b1;
        step();
        ctrl_base_addr   = {$urandom, $urandom};
        ctrl_total_bytes = $urandom;
        ap_start = 1'b0;
        check("start_latency", 64'(eng_start), 64'(exp_n != 0));
        check("timeout_clear_on_start", 64'(sched_timeout), 64'd0);

        while (!finished && cycles < 2000) begin
            eng_done_nx = 1'b0;
            if (done_driven) begin
                check("done_to_next", 64'(eng_start | ap_done), 64'd1);
                done_driven = 0;
            end
            if (eng_start) begin
                if (exp_addr_q.size() == 0) begin
                    check("extra_start", 64'(n_starts + 1), 64'(exp_n));
                end else begin
                    ea = exp_addr_q.pop_front();
                    es = exp_size_q.pop_front();
                    check("chunk_addr", eng_addr_offset, ea);
                    check("chunk_size", 64'(eng_xfer_size), 64'(es));
                    check("chunk_idx", 64'(chunk_idx), 64'(n_starts));
                end
                n_starts++;
                last_addr  = eng_addr_offset;
                last_size  = eng_xfer_size;
                done_delay = $urandom_range(0, 5);
                eng_done_nx = disturb;
            end else if (done_delay == 0) begin
                eng_done_nx = 1'b1;
                done_driven = 1;
                done_delay  = -1;
            end else if (done_delay > 0) begin
                done_delay--;
                if (disturb) ap_start = ~ap_start;
            end
            if (ap_done) begin
                n_done++;
                check("done_idle", 64'(ap_idle), 64'd1);
                check("done_all_chunks", 64'(n_starts), 64'(exp_n));
                if (exp_n == 0) check("zero_len_latency", 64'(cycles), 64'd1);
                finished = 1;
            end else if (ap_idle !== 1'b0) begin
                idle_bad++;
            end
            eng_done = eng_done_nx;
            if (!finished) begin
                step();
                cycles++;
            end
        end
        if (!finished) check("job_budget_expired", 64'(cycles), 64'd0);

        eng_done = disturb;
        ap_start = 1'b0;
        step();
        check("done_single", 64'(ap_done), 64'd0);
        check("post_idle", 64'(ap_idle), 64'd1);
        check("post_chunk_idx", 64'(chunk_idx), 64'd0);
        eng_done = 1'b0;
        repeat (3) begin
            step();
            if (ap_done) n_done++;
            if (eng_start) n_starts++;
        end
        check("idle_during_job", 64'(idle_bad), 64'd0);
        check("done_count", 64'(n_done), 64'd1);
        check("start_count", 64'(n_starts), 64'(exp_n));
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs[6];
        int          ns, starts_seen, dones_seen, gap;
        logic [63:0] la;
        logic [31:0] ls;

        vecs[0] = '{64'h0000_0000_1000_0000, 32'd10000, 1'b0, 3, 64'h0000_0000_1000_2000, 32'd1792};
        vecs[1] = '{64'h0000_0000_2000_0040, 32'd0,     1'b0, 0, 64'h0, 32'd0};
        vecs[2] = '{64'h0000_0000_2000_0000, 32'd63,    1'b1, 0, 64'h0, 32'd0};
        vecs[3] = '{64'hFFFF_FFFF_FFFF_F000, 32'd8192,  1'b0, 2, 64'h0, 32'd4096};
        vecs[4] = '{64'h0000_0000_0001_0000, 32'd4160,  1'b1, 2, 64'h0000_0000_0001_1000, 32'd64};
        vecs[5] = '{64'h0000_0000_1000_0000, 32'd10000, 1'b1, 3, 64'h0000_0000_1000_2000, 32'd1792};

        areset = 1'b1;
        ap_start = 1'b0;
        eng_done = 1'b0;
        ctrl_base_addr = '0;
        ctrl_total_bytes = '0;
        repeat (2) step();
        check("rst_idle", 64'(ap_idle), 64'd1);
        check("rst_done", 64'(ap_done), 64'd0);
        check("rst_eng_start", 64'(eng_start), 64'd0);
        check("rst_addr", eng_addr_offset, 64'd0);
        check("rst_size", 64'(eng_xfer_size), 64'd0);
        check("rst_chunk_idx", 64'(chunk_idx), 64'd0);
        check("rst_timeout", 64'(sched_timeout), 64'd0);
        areset = 1'b0;
        step();

        for (int i = 0; i < 6; i++) begin
            run_job(vecs[i].base, vecs[i].total, vecs[i].disturb, ns, la, ls);
            check("vec_chunks", 64'(ns), 64'(vecs[i].exp_chunks));
            if (vecs[i].exp_chunks > 0) begin
                check("vec_last_addr", la, vecs[i].exp_last_addr);
                check("vec_last_size", 64'(ls), 64'(vecs[i].exp_last_size));
            end
        end

        // Reset during WAIT of chunk 1, then a fresh job.
        ctrl_base_addr = 64'h0000_0000_1000_0000;
        ctrl_total_bytes = 32'd10000;
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        check("rstseq_chunk0", 64'(eng_start), 64'd1);
        step();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
        check("rstseq_chunk1", 64'(eng_start), 64'd1);
        check("rstseq_idx1", 64'(chunk_idx), 64'd1);
        step();
        areset = 1'b1;
        step();
        areset = 1'b0;
        check("rstseq_idle", 64'(ap_idle), 64'd1);
        check("rstseq_eng_start", 64'(eng_start), 64'd0);
        check("rstseq_done", 64'(ap_done), 64'd0);
        check("rstseq_idx", 64'(chunk_idx), 64'd0);
        starts_seen = 0;
        dones_seen  = 0;
        repeat (5) begin
            step();
            if (ap_done) dones_seen++;
            if (eng_start) starts_seen++;
        end
        check("rstseq_quiet", 64'(starts_seen + dones_seen), 64'd0);
        run_job(vecs[0].base, vecs[0].total, 1'b0, ns, la, ls);
        check("rstseq_fresh_chunks", 64'(ns), 64'd3);
        check("rstseq_fresh_last", la, 64'h0000_0000_1000_2000);

`ifdef SDX_SCHED_TIMEOUT_EN
        // Engine never answers: watchdog forces completion after TMO WAIT cycles.
        ctrl_base_addr = 64'h0000_0000_1000_0000;
        ctrl_total_bytes = 32'd10000;
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        check("tmo_first_start", 64'(eng_start), 64'd1);
        gap = 0;
        starts_seen = 0;
        while (!ap_done && gap < 400) begin
            step();
            gap++;
            if (eng_start) starts_seen++;
        end
        check("tmo_latency", 64'(gap), 64'(TMO + 1));
        check("tmo_flag", 64'(sched_timeout), 64'd1);
        check("tmo_no_more_chunks", 64'(starts_seen), 64'd0);
        step();
        check("tmo_sticky", 64'(sched_timeout), 64'd1);
        check("tmo_done_single", 64'(ap_done), 64'd0);
        run_job(vecs[4].base, vecs[4].total, 1'b0, ns, la, ls);
        check("tmo_next_job_chunks", 64'(ns), 64'd2);
`endif

        // Random jobs against the reference model.
        for (int j = 0; j < 25; j++) begin
            logic [63:0] b;
            logic [31:0] t;
            b = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) b = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 12000));
            t = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : 32'($urandom_range(0, 20000));
            run_job(b, t, 1'($urandom_range(0, 1)), ns, la, ls);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
